// File: rtl/dual_bus_ack_responder.sv
// Two independent request/acknowledge channels with latency, stall-timeout forcing,
// overrun reporting and a saturating acknowledge counter.

// state | meaning
// IDLE  | no transaction pending
// WAIT  | request accepted, counting toward the ack latency
// ACK   | ack (and forced, if timed out) asserted for this one cycle
module dual_bus_ack_channel #(
  parameter int LAT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic stall,
  output logic ack,
  output logic forced,
  output logic overrun,
  output logic ack_nxt
);
  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  localparam logic [2:0] LAT_C = 3'(LAT);
  localparam logic [2:0] CNT_MAX = 3'd4;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       req_q;
  logic       rise;
  logic       forced_d, overrun_d;

  assign rise = req & ~req_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ack_nxt   = 1'b0;
    forced_d  = 1'b0;
    overrun_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = WAIT;
          cnt_d   = 3'd0;
        end
      end
      WAIT: begin
        overrun_d = rise;
        if (((cnt_q >= LAT_C) && !stall) || (cnt_q == CNT_MAX)) begin
          state_d  = ACK;
          ack_nxt  = 1'b1;
          // Stalled at exit can only happen on the cnt==4 timeout path.
          forced_d = stall;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ACK: begin
        if (rise) begin
          state_d = WAIT;
          cnt_d   = 3'd0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    req_q <= req;
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      ack     <= 1'b0;
      forced  <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack     <= ack_nxt;
      forced  <= forced_d;
      overrun <= overrun_d;
    end
  end
endmodule

module dual_bus_ack_responder #(
  parameter int LAT1  = 2,
  parameter int LAT2  = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bus_select,
  input  logic             req1,
  input  logic             req2,
  input  logic             busy,
  output logic             ack1,
  output logic             ack2,
  output logic             forced1,
  output logic             forced2,
  output logic [1:0]       overrun,
  output logic [CNT_W-1:0] ack_cnt
);
  logic stall1, stall2;
  logic ack1_nxt, ack2_nxt;
  logic ovr1, ovr2;
  logic [1:0] inc;
  logic [CNT_W:0] sum;

  assign stall1 = busy & ~bus_select;
  assign stall2 = busy & bus_select;

  dual_bus_ack_channel #(.LAT(LAT1)) u_ch1 (
    .clk(clk), .reset(reset), .req(req1), .stall(stall1),
    .ack(ack1), .forced(forced1), .overrun(ovr1), .ack_nxt(ack1_nxt)
  );

  dual_bus_ack_channel #(.LAT(LAT2)) u_ch2 (
    .clk(clk), .reset(reset), .req(req2), .stall(stall2),
    .ack(ack2), .forced(forced2), .overrun(ovr2), .ack_nxt(ack2_nxt)
  );

  assign overrun = {ovr2, ovr1};

  // Count from the next-state acks so ack_cnt moves in the same cycle as the pulses.
  assign inc = {1'b0, ack1_nxt} + {1'b0, ack2_nxt};
  assign sum = {1'b0, ack_cnt} + {{(CNT_W-1){1'b0}}, inc};

  always_ff @(posedge clk) begin
    if (reset) ack_cnt <= '0;
    else       ack_cnt <= sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  end
endmodule

// File: tb/tb_dual_bus_ack_responder.sv
// Randomized and directed bench for dual_bus_ack_responder against a deadline-based model.
module tb_dual_bus_ack_responder;
  logic        clk = 1'b0;
  logic        reset, bus_select, req1, req2, busy;
  logic        ack1, ack2, forced1, forced2;
  logic [1:0]  overrun;
  logic [15:0] ack_cnt;
  logic        b_ack1, b_ack2, b_forced1, b_forced2;
  logic [1:0]  b_overrun;
  logic [3:0]  b_ack_cnt;

  always #5 clk = ~clk;

  dual_bus_ack_responder u_dut (
    .clk(clk), .reset(reset), .bus_select(bus_select), .req1(req1), .req2(req2),
    .busy(busy), .ack1(ack1), .ack2(ack2), .forced1(forced1), .forced2(forced2),
    .overrun(overrun), .ack_cnt(ack_cnt)
  );

  dual_bus_ack_responder #(.CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .bus_select(bus_select), .req1(req1), .req2(req2),
    .busy(busy), .ack1(b_ack1), .ack2(b_ack2), .forced1(b_forced1), .forced2(b_forced2),
    .overrun(b_overrun), .ack_cnt(b_ack_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: a request accepted in cycle t must exit WAIT in the first cycle c in
  // [t+1+LAT, t+5] that is unstalled, or at t+5 regardless (forced if stalled).
  int lat [2] = '{2, 3};
  bit act [2];
  bit prev [2];
  int st [2];
  int cyc = 0;
  int total = 0;
  bit e_ack [2], e_frc [2], e_ovr [2];

  task automatic model_ch(input int ch, input bit r, input bit rq, input bit stl);
    bit rise;
    e_ack[ch] = 0; e_frc[ch] = 0; e_ovr[ch] = 0;
    if (r) begin
      act[ch] = 0;
      prev[ch] = rq;
    end else begin
      rise = rq && !prev[ch];
      prev[ch] = rq;
      if (act[ch]) begin
        if (rise) e_ovr[ch] = 1;
        if ((cyc >= st[ch] + 1 + lat[ch] && !stl) || cyc == st[ch] + 5) begin
          e_ack[ch] = 1;
          e_frc[ch] = stl;
          act[ch] = 0;
        end
      end else if (rise) begin
        act[ch] = 1;
        st[ch] = cyc;
      end
    end
  endtask

  int ofs, ack1_at, ack2_at, n_ack1, n_ack2, ovr_at, frc1_seen, frc2_seen;
  logic [1:0] ovr_val;

  task automatic clr_rec();
    ofs = 0; ack1_at = -1; ack2_at = -1; n_ack1 = 0; n_ack2 = 0;
    ovr_at = -1; ovr_val = 2'b00; frc1_seen = 0; frc2_seen = 0;
  endtask

  task automatic step(input bit r, input bit bs, input bit q1, input bit q2, input bit b);
    int e4, e16;
    reset = r; bus_select = bs; req1 = q1; req2 = q2; busy = b;
    model_ch(0, r, q1, b && !bs);
    model_ch(1, r, q2, b && bs);
    if (r) total = 0;
    else   total += int'(e_ack[0]) + int'(e_ack[1]);
    cyc++;
    @(negedge clk);
    e16 = (total > 65535) ? 65535 : total;
    e4  = (total > 15) ? 15 : total;
    check("ack1", ack1, e_ack[0]);
    check("ack2", ack2, e_ack[1]);
    check("forced1", forced1, e_frc[0]);
    check("forced2", forced2, e_frc[1]);
    check("overrun", overrun, {e_ovr[1], e_ovr[0]});
    check("ack_cnt", ack_cnt, e16);
    check("ack_cnt4", b_ack_cnt, e4);
    check("ack1_w4", b_ack1, e_ack[0]);
    ofs++;
    if (ack1) begin n_ack1++; if (ack1_at < 0) ack1_at = ofs; end
    if (ack2) begin n_ack2++; if (ack2_at < 0) ack2_at = ofs; end
    if (forced1) frc1_seen++;
    if (forced2) frc2_seen++;
    if (overrun != 2'b00 && ovr_at < 0) begin ovr_at = ofs; ovr_val = overrun; end
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0);
  endtask

  initial begin
    reset = 1; bus_select = 1; req1 = 0; req2 = 0; busy = 0;
    @(negedge clk);
    do_reset();
    check("rst_ack_cnt", ack_cnt, 0);

    // Unstalled channel 1: ack at t+4, not forced.
    step(0, 1, 0, 0, 0);
    clr_rec();
    step(0, 1, 1, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 1, 0, 0);
    check("t34_ack1_at", ack1_at, 4);
    check("t34_n_ack1", n_ack1, 1);
    check("t34_forced1", frc1_seen, 0);
    check("t34_cnt", ack_cnt, 1);

    // Channel 2 stalled throughout: forced ack at t+6.
    do_reset();
    step(0, 1, 0, 0, 1);
    clr_rec();
    step(0, 1, 0, 1, 1);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 1, 1);
    check("t35_ack2_at", ack2_at, 6);
    check("t35_forced2", frc2_seen, 1);

    // Simultaneous rises.
    do_reset();
    step(0, 1, 0, 0, 0);
    clr_rec();
    step(0, 1, 1, 1, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 1, 1, 0);
    check("t36_ack1_at", ack1_at, 4);
    check("t36_ack2_at", ack2_at, 5);
    check("t36_cnt", ack_cnt, 2);

    // Second rise while waiting is dropped.
    do_reset();
    step(0, 1, 0, 0, 0);
    clr_rec();
    step(0, 1, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 1, 0, 0);
    check("t37_ovr_at", ovr_at, 3);
    check("t37_ovr_val", ovr_val, 2'b01);
    check("t37_ack1_at", ack1_at, 4);
    check("t37_n_ack1", n_ack1, 1);

    // Reset mid-transaction with req1 held high.
    do_reset();
    step(0, 1, 0, 0, 0);
    clr_rec();
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 1, 0, 0);
    check("t38_n_ack1", n_ack1, 0);
    check("t38_cnt", ack_cnt, 0);

    // Many acks saturate the 4-bit counter.
    do_reset();
    for (int k = 0; k < 24; k++) begin
      step(0, 1, 1, 1, 0);
      for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0);
    end
    check("t39_cnt4", b_ack_cnt, 15);
    check("t39_cnt16", ack_cnt, 48);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 299) == 0),
           $urandom_range(0, 1) == 1,
           ($urandom_range(0, 3) == 0) ? ~req1 : req1,
           ($urandom_range(0, 3) == 0) ? ~req2 : req2,
           $urandom_range(0, 2) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/dual_bus_ack_responder.md
DUAL_BUS_ACK_RESPONDER -- requirements
Module: dual_bus_ack_responder

Interface
REQ-001 SHALL have parameter LAT1, default 2, nominal ack latency of channel 1 (legal 0..4).
REQ-002 SHALL have parameter LAT2, default 3, nominal ack latency of channel 2 (legal 0..4).
REQ-003 SHALL have parameter CNT_W, default 16, width of the ack counter.
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 SHALL have port clk  input  1  rising-edge clock.
REQ-006 SHALL have port reset  input  1  synchronous active-high reset.
REQ-007 SHALL have port bus_select  input  1  active bus: 1 = bus1, 0 = bus2.
REQ-008 SHALL have port req1  input  1  bus1 request level.
REQ-009 SHALL have port req2  input  1  bus2 request level.
REQ-010 SHALL have port busy  input  1  stall for the non-selected channel.
REQ-011 SHALL have port ack1  output  1  bus1 acknowledge, one-cycle pulse.
REQ-012 SHALL have port ack2  output  1  bus2 acknowledge, one-cycle pulse.
REQ-013 SHALL have port forced1  output  1  pulses with ack1 when the ack was timeout-forced.
REQ-014 SHALL have port forced2  output  1  pulses with ack2 when the ack was timeout-forced.
REQ-015 SHALL have port overrun  output  2  bit0/bit1 pulse when a req1/req2 rise is dropped.
REQ-016 SHALL have port ack_cnt  output  CNT_W  saturating total of ack1 plus ack2 pulses.

Function
REQ-017 SHALL detect a rise on reqN as reqN=1 this cycle and the registered reqN_q=0; the rise cycle is t.
REQ-018 SHALL run two independent channels, each an FSM with states IDLE, WAIT and ACK and a 3-bit wait counter cnt.
REQ-019 SHALL move a channel from IDLE to WAIT on a rise, with cnt=0 in cycle t+1.
REQ-020 SHALL treat a channel as stalled when busy=1 and the channel is not selected by bus_select; the selected channel is never stalled.
REQ-021 SHALL, in WAIT, go to ACK when (cnt>=LATN and not stalled) or cnt==4; otherwise it SHALL increment cnt.
REQ-022 SHALL drive ackN=1 for exactly the one cycle spent in ACK, then return to IDLE.
REQ-023 SHALL give an unstalled ack in cycle t+2+LATN, and an ack no later than t+6 in all cases (satisfies rose(req) |=> ##[0:5] ack).
REQ-024 SHALL assert forcedN together with ackN only when the WAIT-to-ACK exit was due to cnt==4 while stalled with cnt>=LATN, or cnt==4 with LATN==4 while stalled.
REQ-025 SHALL accept a rise seen in ACK state as a new request (ACK to WAIT, cnt=0).
REQ-026 SHALL drop a rise seen in WAIT, leave the transaction in progress unaffected, and pulse overrun[N-1] in the next cycle.
REQ-027 SHALL let channels act independently: simultaneous rises produce both acks; simultaneous ack1 and ack2 add 2 to ack_cnt.
REQ-028 SHALL saturate ack_cnt at all-ones, with no wrap.
REQ-029 SHALL make a bus_select change take effect on the stall decision in the same cycle.
REQ-030 SHALL register every output with no combinational input-to-output path.

Reset
REQ-031 SHALL, while reset=1, place both channels in IDLE with cnt=0, and drive ack1, ack2, forced1, forced2, overrun and ack_cnt to 0.
REQ-032 SHALL, while reset=1, load reqN_q with reqN so that a request held high through reset gives no rise.
REQ-033 SHALL abort any transaction when reset is asserted mid-operation; no ack is issued for it afterwards.

Verification
REQ-034 SHALL be checked for: bus_select=1, busy=0, req1 rises at t -> ack1=1 only at t+4 (LAT1=2), forced1=0, ack_cnt=1.
REQ-035 SHALL be checked for: bus_select=1, busy=1 held, req2 rises at t -> ack2 at t+6, forced2=1.
REQ-036 SHALL be checked for: req1 and req2 rise in the same cycle t, busy=0 -> ack1 at t+4, ack2 at t+5, ack_cnt=2.
REQ-037 SHALL be checked for: req1 rises at t, falls, and rises again at t+2 -> overrun=01 at t+3, single ack1 at t+4.
REQ-038 SHALL be checked for: reset asserted at t+2 after a req1 rise at t, req1 held high -> no ack1 and no rise detected after reset.
REQ-039 SHALL be checked for: 2^CNT_W+3 acks (CNT_W=4 build) -> ack_cnt holds 15.
